// File: rtl/main_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control unit: state encoding,
// opcodes, alu_op codes and datapath select values.
// Optional feature macro: MAIN_CTRL_ADDI_EN (compiles in the addi path).
package main_ctrl_pkg;

    // Fixed state encoding; the value is exported on the debug state port.
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiEx   = 4'd10,
        StAddiWb   = 4'd11,
        StReset    = 4'd15
    } state_e;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    // alu_op codes consumed by alu_control_block; bit 2 is always 0.
    localparam logic [2:0] AluOpAdd   = 3'b000;
    localparam logic [2:0] AluOpSub   = 3'b001;
    localparam logic [2:0] AluOpRType = 3'b010;

    // alu_src_b selects
    localparam logic [1:0] AluSrcBReg    = 2'b00;
    localparam logic [1:0] AluSrcBFour   = 2'b01;
    localparam logic [1:0] AluSrcBImm    = 2'b10;
    localparam logic [1:0] AluSrcBImmSh2 = 2'b11;

    // pc_source selects
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    // True when DECODE can dispatch the opcode to an execution path.
    function automatic logic is_supported_op(input logic [5:0] op);
        logic ok;
        ok = (op == OpRType) || (op == OpLw) || (op == OpSw) ||
             (op == OpBeq) || (op == OpJ);
`ifdef MAIN_CTRL_ADDI_EN
        ok = ok || (op == OpAddi);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/main_ctrl_decode.sv
// Combinational output decoder: maps the current state (and mem_ready, which
// qualifies the FETCH loads) to every datapath control signal.
// Optional feature macro: MAIN_CTRL_ADDI_EN (decodes the addi states).
module main_ctrl_decode
    import main_ctrl_pkg::*;
(
    input  state_e     i_state,
    input  logic       i_mem_ready,
    output logic [2:0] o_alu_op,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic [1:0] o_pc_source,
    output logic       o_i_or_d,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_reg_write
);

    // Per-state control decode; everything defaults to 0 so RESET and unused
    // encodings drive an idle datapath.
    always_comb begin
        o_alu_op        = AluOpAdd;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = AluSrcBReg;
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_pc_source     = PcSrcAlu;
        o_i_or_d        = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_reg_dst       = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_write     = 1'b0;
        case (i_state)
            StFetch: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = AluSrcBFour;
                // IR and PC load only on the cycle the fetch completes
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            StDecode: begin
                o_alu_src_b = AluSrcBImmSh2;
            end
            StMemAddr: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = AluSrcBImm;
            end
            StMemRead: begin
                o_mem_read = 1'b1;
                o_i_or_d   = 1'b1;
            end
            StMemWb: begin
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
            end
            StMemWrite: begin
                o_mem_write = 1'b1;
                o_i_or_d    = 1'b1;
            end
            StExecute: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = AluOpRType;
            end
            StRWb: begin
                o_reg_dst   = 1'b1;
                o_reg_write = 1'b1;
            end
            StBranch: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = AluOpSub;
                o_pc_write_cond = 1'b1;
                o_pc_source     = PcSrcAluOut;
            end
            StJump: begin
                o_pc_write  = 1'b1;
                o_pc_source = PcSrcJump;
            end
`ifdef MAIN_CTRL_ADDI_EN
            StAddiEx: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = AluSrcBImm;
            end
            StAddiWb: begin
                o_reg_write = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control unit: state register plus next-state logic;
// control outputs come from main_ctrl_decode.
// Optional feature macro: MAIN_CTRL_ADDI_EN (addi path; otherwise addi is illegal).
module main_control_fsm
    import main_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output logic [2:0] o_alu_op,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic [1:0] o_pc_source,
    output logic       o_i_or_d,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_reg_write,
    output logic       o_illegal_op,
    output logic [3:0] o_state
);

    state_e r_state;
    state_e w_state_d;
    logic   w_illegal;

    // State register; reset forces RESET immediately so all outputs drop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StReset;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state sequencing and the illegal-opcode pulse.
    always_comb begin
        w_state_d = r_state;
        w_illegal = 1'b0;
        case (r_state)
            StFetch: begin
                if (i_mem_ready) begin
                    w_state_d = StDecode;
                end
            end
            StDecode: begin
                if (!is_supported_op(i_opcode)) begin
                    w_state_d = StFetch;
                    w_illegal = 1'b1;
                end else if (i_opcode == OpRType) begin
                    w_state_d = StExecute;
                end else if ((i_opcode == OpLw) || (i_opcode == OpSw)) begin
                    w_state_d = StMemAddr;
                end else if (i_opcode == OpBeq) begin
                    w_state_d = StBranch;
                end else if (i_opcode == OpJ) begin
                    w_state_d = StJump;
                end else begin
                    w_state_d = StAddiEx;
                end
            end
            // IR is only loaded in FETCH, so the opcode is still valid here
            StMemAddr: begin
                w_state_d = (i_opcode == OpSw) ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                if (i_mem_ready) begin
                    w_state_d = StMemWb;
                end
            end
            StMemWrite: begin
                if (i_mem_ready) begin
                    w_state_d = StFetch;
                end
            end
            StExecute: begin
                w_state_d = StRWb;
            end
`ifdef MAIN_CTRL_ADDI_EN
            StAddiEx: begin
                w_state_d = StAddiWb;
            end
`endif
            // RESET, single-cycle tail states and unused encodings
            default: begin
                w_state_d = StFetch;
            end
        endcase
    end

    main_ctrl_decode u_decode (
        .i_state         (r_state),
        .i_mem_ready     (i_mem_ready),
        .o_alu_op        (o_alu_op),
        .o_alu_src_a     (o_alu_src_a),
        .o_alu_src_b     (o_alu_src_b),
        .o_pc_write      (o_pc_write),
        .o_pc_write_cond (o_pc_write_cond),
        .o_pc_source     (o_pc_source),
        .o_i_or_d        (o_i_or_d),
        .o_mem_read      (o_mem_read),
        .o_mem_write     (o_mem_write),
        .o_ir_write      (o_ir_write),
        .o_reg_dst       (o_reg_dst),
        .o_mem_to_reg    (o_mem_to_reg),
        .o_reg_write     (o_reg_write)
    );

    assign o_illegal_op = w_illegal;
    assign o_state      = r_state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: a directed vector table, hand-written
// reset/stall sequences and randomized instructions checked per cycle against a
// timeline model built from the instruction paths and per-state output table.
module tb_main_control_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic [3:0] state;

    int n_cmp  = 0;
    int n_fail = 0;

    main_control_fsm dut (
        .clk             (clk),
        .rst             (rst),
        .i_opcode        (opcode),
        .i_mem_ready     (mem_ready),
        .o_alu_op        (alu_op),
        .o_alu_src_a     (alu_src_a),
        .o_alu_src_b     (alu_src_b),
        .o_pc_write      (pc_write),
        .o_pc_write_cond (pc_write_cond),
        .o_pc_source     (pc_source),
        .o_i_or_d        (i_or_d),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_ir_write      (ir_write),
        .o_reg_dst       (reg_dst),
        .o_mem_to_reg    (mem_to_reg),
        .o_reg_write     (reg_write),
        .o_illegal_op    (illegal_op),
        .o_state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_BAD  = 6'h3f;

    // Bundle order: alu_op, src_a, src_b, pc_write, pc_write_cond, pc_source,
    // i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal
    logic [17:0] act_bus;
    assign act_bus = {alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source,
                      i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                      reg_write, illegal_op};

    function automatic logic legal_op(input logic [5:0] op);
        logic ok;
        ok = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
`ifdef MAIN_CTRL_ADDI_EN
        ok = ok || (op == OP_ADDI);
`endif
        return ok;
    endfunction

    // Expected control bundle for a state, straight from the state output table.
    function automatic logic [17:0] exp_outs(input int st, input logic mr, input logic [5:0] op);
        logic [2:0] a_op;
        logic       sa, pcw, pcwc, iod, mrd, mwr, irw, rd, m2r, rw, ill;
        logic [1:0] sb, ps;
        {a_op, sa, sb, pcw, pcwc, ps, iod, mrd, mwr, irw, rd, m2r, rw, ill} = '0;
        case (st)
            0: begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            1: begin sb = 2'b11; ill = !legal_op(op); end
            2: begin sa = 1; sb = 2'b10; end
            3: begin mrd = 1; iod = 1; end
            4: begin m2r = 1; rw = 1; end
            5: begin mwr = 1; iod = 1; end
            6: begin sa = 1; a_op = 3'b010; end
            7: begin rd = 1; rw = 1; end
            8: begin sa = 1; a_op = 3'b001; pcwc = 1; ps = 2'b01; end
            9: begin pcw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {a_op, sa, sb, pcw, pcwc, ps, iod, mrd, mwr, irw, rd, m2r, rw, ill};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, then check state and bundle.
    task automatic cyc(input logic [5:0] op, input logic mr, input int st);
        @(negedge clk);
        opcode    = op;
        mem_ready = mr;
        #1;
        check("state", {28'd0, state}, st[31:0]);
        check("outputs", {14'd0, act_bus}, {14'd0, exp_outs(st, mr, op)});
    endtask

    // Expand an instruction into its expected per-cycle state timeline.
    // mem_ready is randomized in states that must ignore it.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) cyc(op, 1'b0, 0);
        cyc(op, 1'b1, 0);
        cyc(op, 1'($urandom), 1);
        if (op == OP_R) begin
            cyc(op, 1'($urandom), 6);
            cyc(op, 1'($urandom), 7);
        end else if (op == OP_LW) begin
            cyc(op, 1'($urandom), 2);
            for (int i = 0; i < mw; i++) cyc(op, 1'b0, 3);
            cyc(op, 1'b1, 3);
            cyc(op, 1'($urandom), 4);
        end else if (op == OP_SW) begin
            cyc(op, 1'($urandom), 2);
            for (int i = 0; i < mw; i++) cyc(op, 1'b0, 5);
            cyc(op, 1'b1, 5);
        end else if (op == OP_BEQ) begin
            cyc(op, 1'($urandom), 8);
        end else if (op == OP_J) begin
            cyc(op, 1'($urandom), 9);
        end
`ifdef MAIN_CTRL_ADDI_EN
        else if (op == OP_ADDI) begin
            cyc(op, 1'($urandom), 10);
            cyc(op, 1'($urandom), 11);
        end
`endif
    endtask

    typedef struct {
        logic [5:0] op;
        logic       mr;
        logic [3:0] st;
        logic [2:0] alu_op;
        logic       rw;
        logic       rdst;
        logic       pcwc;
        logic [1:0] pcsrc;
        logic       irw;
        logic       pcw;
        logic       ill;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [5:0] rop;
        // R-type from reset, beq, fetch stall then j, illegal opcode
        tbl[0]  = '{OP_R,   1'b1, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{OP_R,   1'b1, 4'd1, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{OP_R,   1'b1, 4'd6, 3'b010, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{OP_R,   1'b1, 4'd7, 3'b000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{OP_BEQ, 1'b1, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{OP_BEQ, 1'b1, 4'd1, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{OP_BEQ, 1'b1, 4'd8, 3'b001, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{OP_J,   1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{OP_J,   1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{OP_J,   1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{OP_J,   1'b1, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{OP_J,   1'b1, 4'd1, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{OP_J,   1'b1, 4'd9, 3'b000, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{OP_BAD, 1'b1, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{OP_BAD, 1'b1, 4'd1, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{OP_BAD, 1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

        rst       = 1'b0;
        opcode    = OP_R;
        mem_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_reset_state", {28'd0, state}, 32'd15);
        check("async_reset_outputs", {14'd0, act_bus}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset_hold_state", {28'd0, state}, 32'd15);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            opcode    = tbl[i].op;
            mem_ready = tbl[i].mr;
            #1;
            check($sformatf("tbl%0d_state", i), {28'd0, state}, {28'd0, tbl[i].st});
            check($sformatf("tbl%0d_ctrl", i),
                  {21'd0, alu_op, reg_write, reg_dst, pc_write_cond, pc_source, ir_write,
                   pc_write, illegal_op},
                  {21'd0, tbl[i].alu_op, tbl[i].rw, tbl[i].rdst, tbl[i].pcwc, tbl[i].pcsrc,
                   tbl[i].irw, tbl[i].pcw, tbl[i].ill});
        end

        // lw with two MEM_READ wait cycles, then addi (legal or illegal per build)
        run_instr(OP_LW, 0, 2);
        run_instr(OP_ADDI, 1, 0);
        run_instr(OP_SW, 0, 1);

        // sw interrupted by reset in MEM_WRITE, between clock edges
        cyc(OP_SW, 1'b1, 0);
        cyc(OP_SW, 1'b1, 1);
        cyc(OP_SW, 1'b1, 2);
        cyc(OP_SW, 1'b0, 5);
        #2 rst = 1'b1;
        #1;
        check("mid_sw_reset_state", {28'd0, state}, 32'd15);
        check("mid_sw_reset_mem_write", {31'd0, mem_write}, 32'd0);
        check("mid_sw_reset_outputs", {14'd0, act_bus}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(OP_R, 1'b0, 0);

        // Randomized instruction mix with random wait states
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: rop = OP_R;
                1: rop = OP_LW;
                2: rop = OP_SW;
                3: rop = OP_BEQ;
                4: rop = OP_J;
                5: rop = OP_ADDI;
                default: rop = 6'($urandom);
            endcase
            run_instr(rop, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        cyc(OP_R, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main control unit for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the datapath mux selects and write enables, and produces the 3-bit `alu_op` code that `alu_control_block` consumes alongside `func`. It is the producer end of the `alu_op` interface, and it stalls on a memory-ready handshake.

## Interface
Parameters:
- none; all encodings are fixed constants.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  `instr[31:26]` from the instruction register; sampled in DECODE.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `alu_op`  out  3  to `alu_control_block`:
  - 000 = add
  - 001 = subtract
  - 010 = R-type, use `func`
  - bit 2 is always 0.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load qualified by the ALU zero flag (qualification happens in the datapath).
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `i_or_d`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `ir_write`  out  1  instruction register load.
- `reg_dst`  out  1  register-file write address: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  register write data: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register-file write enable.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `state`  out  4  current state, for debug.

## Operation
States (encoding):
- RESET = 15: all outputs 0; always goes to FETCH.
- FETCH = 0:
  - Outputs: `mem_read=1`, `i_or_d=0`, `alu_src_a=0`, `alu_src_b=01`, `alu_op=000`, `pc_source=00`.
  - `ir_write` and `pc_write` are asserted only while `mem_ready=1`.
  - Goes to DECODE when `mem_ready=1`; otherwise holds in FETCH.
- DECODE = 1: `alu_src_a=0`, `alu_src_b=11`, `alu_op=000`. Next state by opcode:
  - 000000 (R-type) → EXECUTE
  - 100011 (lw) and 101011 (sw) → MEM_ADDR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDI_EX
  - any other opcode → FETCH, with `illegal_op=1` this cycle.
- MEM_ADDR = 2: `alu_src_a=1`, `alu_src_b=10`, `alu_op=000`. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ = 3: `mem_read=1`, `i_or_d=1`. Holds until `mem_ready=1`, then goes to MEM_WB.
- MEM_WB = 4: `reg_dst=0`, `mem_to_reg=1`, `reg_write=1`. → FETCH.
- MEM_WRITE = 5: `mem_write=1`, `i_or_d=1`. Holds until `mem_ready=1`, then goes to FETCH.
- EXECUTE = 6: `alu_src_a=1`, `alu_src_b=00`, `alu_op=010`. → R_WB.
- R_WB = 7: `reg_dst=1`, `mem_to_reg=0`, `reg_write=1`. → FETCH.
- BRANCH = 8: `alu_src_a=1`, `alu_src_b=00`, `alu_op=001`, `pc_write_cond=1`, `pc_source=01`. → FETCH.
- JUMP = 9: `pc_write=1`, `pc_source=10`. → FETCH.
- ADDI_EX = 10: `alu_src_a=1`, `alu_src_b=10`, `alu_op=000`. → ADDI_WB.
- ADDI_WB = 11: `reg_dst=0`, `mem_to_reg=0`, `reg_write=1`. → FETCH.
- Unused encodings 12–14: all outputs 0; go to FETCH.

General output rules:
- Any output not listed for a state is 0 in that state.
- `mem_read` and `mem_write` are never high in the same cycle.

## Timing
- The state register is the only storage. Outputs are combinational from `state`; the only exception is the FETCH `mem_ready` qualification of `ir_write`/`pc_write`.
- Reset behaviour:
  - Asserting `rst` forces RESET immediately, without waiting for a clock edge, so every output is 0 from that point.
  - The first rising edge after `rst` deasserts enters FETCH.
- Reset mid-instruction abandons the instruction; no partial write occurs after `rst` asserts.
- `mem_ready` is sampled on the rising edge in FETCH, MEM_READ and MEM_WRITE, and ignored in all other states.
- Cycles per instruction with zero wait states, counted from FETCH entry back to FETCH:
  - R-type 4
  - lw 5
  - sw 4
  - beq 3
  - j 3
  - addi 4
  - each wait cycle adds one.
- `illegal_op` is high for exactly the DECODE cycle.

## Configuration
- `MAIN_CTRL_ADDI_EN`:
  - Defined: the addi path (ADDI_EX, ADDI_WB) is compiled in.
  - Undefined: opcode 001000 is treated as illegal (DECODE → FETCH with `illegal_op=1`), and encodings 10 and 11 behave as unused encodings.

## Structure
- Package `main_ctrl_pkg` holds:
  - state encoding constants
  - opcode constants
  - `alu_op` codes (ADD = 000, SUB = 001, RTYPE = 010), shared with `alu_control_block` testbenches
  - `alu_src_b` and `pc_source` select constants.
- One sub-module, `main_ctrl_decode`: purely combinational, mapping (`state`, `mem_ready`) to all control outputs. `main_control_fsm` keeps the state register and next-state logic.

## Test plan
- Reset release with `mem_ready=1` and opcode 000000:
  - `state` sequence 0, 1, 6, 7, 0.
  - `alu_op=010` only in state 6.
  - `reg_write=1` with `reg_dst=1` only in state 7.
- lw (100011) with `mem_ready` low for 2 cycles in MEM_READ:
  - sequence 0, 1, 2, 3, 3, 3, 4, 0.
  - `mem_to_reg=1` and `reg_write=1` in state 4.
- beq (000100): sequence 0, 1, 8, 0, with `alu_op=001`, `pc_write_cond=1` and `pc_source=01` in state 8.
- FETCH with `mem_ready=0` for 3 cycles: stays in state 0 with `ir_write=0` and `pc_write=0`; both pulse exactly once, in the cycle `mem_ready=1`.
- Opcode 111111: `illegal_op` is 1 for one cycle in state 1, then state 0. With `MAIN_CTRL_ADDI_EN` undefined, opcode 001000 gives the same response.
- sw (101011): assert `rst` asynchronously mid-MEM_WRITE. `mem_write` drops to 0 before the next edge and `state=15`; after release, `state` returns to 0.
